multi_channel_time_adjuster: RTL and testbench

- Cursor-driven editor for one clock-time channel and `NUM_ALARMS` alarm channels, each holding hours (0–23) and minutes (0–59).
- Sits between the button debouncer and the timekeeping/alarm-compare logic. It captures the running time on entry, lets the user walk a cursor across all hour/minute fields and step them up or down, then exports edited values and per-channel dirty flags.
- Generalises the single-alarm adjust block with:
  - a parametrised alarm count;
  - optional minute-to-hour carry;
  - hold-to-auto-repeat on the up/down buttons.

---
 rtl/multi_channel_time_adjuster.sv | 159 +++++++++++++++
 tb/tb_multi_channel_time_adjuster.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_time_adjuster.sv
// multi_channel_time_adjuster: cursor-driven hour/minute editor for one clock channel and NUM_ALARMS alarm channels
module multi_channel_time_adjuster #(
    parameter int NUM_ALARMS    = 2,
    parameter int MINUTE_CARRY  = 1,
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    localparam int FIELDS       = 2 * (NUM_ALARMS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic [4:0]              cur_hours,
    input  logic [5:0]              cur_minutes,
    output logic [4:0]              time_hours_out,
    output logic [5:0]              time_minutes_out,
    output logic [5*NUM_ALARMS-1:0] alarm_hours_flat,
    output logic [6*NUM_ALARMS-1:0] alarm_minutes_flat,
    output logic [4:0]              disp_hours,
    output logic [5:0]              disp_minutes,
    output logic [FIELDS-1:0]       cursor,
    output logic [NUM_ALARMS:0]     dirty
);
    localparam int CH      = NUM_ALARMS + 1;
    localparam int CNT_MAX = HOLD_DELAY > REPEAT_PERIOD ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, EDIT} state_t;

    state_t          r_state, w_state, w_next;
    logic [4:0]      r_hours [CH];
    logic [5:0]      r_mins [CH];
    logic [4:0]      w_hours_nxt [CH];
    logic [5:0]      w_mins_nxt [CH];
    logic [CH-1:0]   w_touch;
    logic [FIELDS-1:0] r_cursor;
    logic [CH-1:0]   r_dirty;
    logic            r_up_d, r_dn_d, r_active, r_dir, r_rep;
    logic [CW-1:0]   r_cnt;
    logic            w_edit, w_up_only, w_dn_only, w_edge_up, w_edge_dn;
    logic            w_hold, w_rep_step, w_step, w_down;
    logic [CW-1:0]   w_thr;

    function automatic logic [4:0] step_h(input logic [4:0] h, input logic dn);
        return dn ? (h == 5'd0 ? 5'd23 : h - 5'd1) : (h == 5'd23 ? 5'd0 : h + 5'd1);
    endfunction

    function automatic logic [5:0] step_m(input logic [5:0] m, input logic dn);
        return dn ? (m == 6'd0 ? 6'd59 : m - 6'd1) : (m == 6'd59 ? 6'd0 : m + 6'd1);
    endfunction

    // The capture cycle is the IDLE cycle in which enable is first seen, so values land one edge later
    always_comb begin
        w_state = (r_state == IDLE && enable) ? CAPTURE : r_state;
        w_next  = w_state;
        if (w_state == CAPTURE) w_next = EDIT;
        else if (w_state == EDIT && !enable) w_next = IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    assign w_edit     = w_state == EDIT;
    assign w_up_only  = btn_up & ~btn_down;
    assign w_dn_only  = btn_down & ~btn_up;
    assign w_edge_up  = w_up_only & ~r_up_d;
    assign w_edge_dn  = w_dn_only & ~r_dn_d;
    assign w_hold     = r_active & (r_dir ? w_dn_only : w_up_only);
    assign w_thr      = r_rep ? CW'(REPEAT_PERIOD) : CW'(HOLD_DELAY);
    assign w_rep_step = w_hold & (r_cnt == w_thr);
    assign w_step     = w_edit & (w_edge_up | w_edge_dn | w_rep_step);
    assign w_down     = w_edge_dn | (w_rep_step & r_dir);

    // Button edge history and hold-to-repeat counter; cnt counts edges since the last step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r_up_d, r_dn_d, r_active, r_dir, r_rep} <= '0;
            r_cnt <= '0;
        end else begin
            r_up_d <= btn_up;
            r_dn_d <= btn_down;
            if (w_edit && (w_edge_up || w_edge_dn)) begin
                {r_active, r_dir, r_rep} <= {1'b1, w_edge_dn, 1'b0};
                r_cnt <= CW'(1);
            end else if (w_edit && w_rep_step) begin
                r_rep <= 1'b1;
                r_cnt <= CW'(1);
            end else if (w_edit && w_hold) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                {r_active, r_dir, r_rep} <= '0;
                r_cnt <= '0;
            end
        end
    end

    // Next field values for the stepped channel, plus the display mux of the channel under the cursor
    always_comb begin
        w_touch      = '0;
        disp_hours   = '0;
        disp_minutes = '0;
        for (int c = 0; c < CH; c++) begin
            w_hours_nxt[c] = r_hours[c];
            w_mins_nxt[c]  = r_mins[c];
            w_touch[c]     = w_step & (r_cursor[2*c] | r_cursor[2*c+1]);
            if (w_step && r_cursor[2*c]) w_hours_nxt[c] = step_h(r_hours[c], w_down);
            if (w_step && r_cursor[2*c+1]) begin
                w_mins_nxt[c] = step_m(r_mins[c], w_down);
                if (MINUTE_CARRY != 0 && r_mins[c] == (w_down ? 6'd0 : 6'd59))
                    w_hours_nxt[c] = step_h(r_hours[c], w_down);
            end
            if (r_cursor[2*c] || r_cursor[2*c+1]) begin
                disp_hours   = r_hours[c];
                disp_minutes = r_mins[c];
            end
        end
    end

    // Channel values, cursor and dirty flags; capture saturates out-of-range running time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                r_hours[c] <= '0;
                r_mins[c]  <= '0;
            end
            r_cursor <= FIELDS'(1);
            r_dirty  <= '0;
        end else if (w_state == CAPTURE) begin
            r_hours[0] <= cur_hours > 5'd23 ? 5'd23 : cur_hours;
            r_mins[0]  <= cur_minutes > 6'd59 ? 6'd59 : cur_minutes;
            r_cursor   <= FIELDS'(1);
            r_dirty    <= '0;
        end else if (w_edit) begin
            for (int c = 0; c < CH; c++) begin
                r_hours[c] <= w_hours_nxt[c];
                r_mins[c]  <= w_mins_nxt[c];
            end
            r_dirty  <= r_dirty | w_touch;
            r_cursor <= btn_right ? {r_cursor[FIELDS-2:0], r_cursor[FIELDS-1]} :
                        btn_left  ? {r_cursor[0], r_cursor[FIELDS-1:1]} : r_cursor;
        end
    end

    assign time_hours_out   = r_hours[0];
    assign time_minutes_out = r_mins[0];
    assign cursor           = r_cursor;
    assign dirty            = r_dirty;

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
        assign alarm_hours_flat[5*k +: 5]   = r_hours[k+1];
        assign alarm_minutes_flat[6*k +: 6] = r_mins[k+1];
    end
endmodule

// File: tb/tb_multi_channel_time_adjuster.sv
// tb_multi_channel_time_adjuster: scoreboard bench for the multi-channel time adjuster
module tb_multi_channel_time_adjuster;
    logic clk, reset, enable, bl, br, bu, bd;
    logic [4:0] ch;
    logic [5:0] cm;
    logic [4:0] th, dh, nth, ndh;
    logic [5:0] tm, dm, ntm, ndm;
    logic [9:0] ah, nah;
    logic [11:0] am, nam;
    logic [5:0] cur, ncur;
    logic [2:0] dirty, ndirty;
    logic [52:0] obs, e;
    logic [52:0] sb [$];
    int checks = 0;
    int failures = 0;
    int mh [3];
    int mm [3];
    int mpos;
    logic [2:0] md;

    multi_channel_time_adjuster #(.NUM_ALARMS(2), .MINUTE_CARRY(1), .HOLD_DELAY(4), .REPEAT_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .cur_hours(ch), .cur_minutes(cm), .time_hours_out(th), .time_minutes_out(tm),
        .alarm_hours_flat(ah), .alarm_minutes_flat(am), .disp_hours(dh), .disp_minutes(dm),
        .cursor(cur), .dirty(dirty));

    multi_channel_time_adjuster #(.NUM_ALARMS(2), .MINUTE_CARRY(0), .HOLD_DELAY(4), .REPEAT_PERIOD(2)) dut_nc (
        .clk(clk), .reset(reset), .enable(enable), .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .cur_hours(ch), .cur_minutes(cm), .time_hours_out(nth), .time_minutes_out(ntm),
        .alarm_hours_flat(nah), .alarm_minutes_flat(nam), .disp_hours(ndh), .disp_minutes(ndm),
        .cursor(ncur), .dirty(ndirty));

    assign obs = {th, tm, ah, am, cur, dirty, dh, dm};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [52:0] exp_vec();
        int c = mpos / 2;
        return {5'(mh[0]), 6'(mm[0]), 5'(mh[2]), 5'(mh[1]), 6'(mm[2]), 6'(mm[1]),
                6'(1 << mpos), md, 5'(mh[c]), 6'(mm[c])};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mh[c] = 0;
            mm[c] = 0;
        end
        mpos = 0;
        md = '0;
    endtask

    task automatic test_reset();
        model_reset();
        sb.push_back(exp_vec());
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset obs=%h exp=%h", obs, e); end
        reset = 1'b0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL idle_no_capture obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_capture();
        ch = 5'd13; cm = 6'd45; enable = 1'b1;
        mh[0] = 13; mm[0] = 45; mpos = 0; md = '0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL capture obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_saturate();
        enable = 1'b0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL leave_edit obs=%h exp=%h", obs, e); end
        enable = 1'b1; ch = 5'd31; cm = 6'd63;
        mh[0] = 23; mm[0] = 59; md = '0; mpos = 0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL saturate obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_carry();
        br = 1'b1; mpos = 1;
        sb.push_back(exp_vec());
        tick();
        br = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL cursor_to_min obs=%h exp=%h", obs, e); end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin bu = 1'b1; mh[0] = 0; mm[0] = 0; end
            else begin bd = 1'b1; mh[0] = 23; mm[0] = 59; end
            md[0] = 1'b1;
            sb.push_back(exp_vec());
            tick();
            bu = 1'b0; bd = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL carry_step%0d obs=%h exp=%h", i, obs, e); end
            checks++;
            if ({nth, ntm} !== {5'd23, (i == 0) ? 6'd0 : 6'd59})
                begin failures++; $display("FAIL nocarry_step%0d got=%0d:%0d", i, nth, ntm); end
            sb.push_back(exp_vec());
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL carry_release%0d obs=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_cursor_walk();
        int mv [9] = '{-1, -1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            if (mv[i] < 0) bl = 1'b1; else br = 1'b1;
            mpos = (mpos + mv[i] + 6) % 6;
            sb.push_back(exp_vec());
            tick();
            bl = 1'b0; br = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL walk%0d obs=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_simultaneous();
        bl = 1'b1; br = 1'b1; mpos = 1;
        sb.push_back(exp_vec());
        tick();
        bl = 1'b0; br = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL left_right obs=%h exp=%h", obs, e); end
        bu = 1'b1; bd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin bu = 1'b0; bd = 1'b0; end
            sb.push_back(exp_vec());
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL up_down_both%0d obs=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_auto_repeat();
        br = 1'b1; mpos = 2;
        sb.push_back(exp_vec());
        tick();
        br = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL cursor_to_alarm obs=%h exp=%h", obs, e); end
        for (int i = 0; i < 4; i++) begin
            bd = (i % 2 == 0);
            if (bd) begin mh[1] = (mh[1] + 23) % 24; md[1] = 1'b1; end
            sb.push_back(exp_vec());
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL alarm_setup%0d obs=%h exp=%h", i, obs, e); end
        end
        bu = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) bu = 1'b0;
            if (k == 0 || k == 4 || k == 6 || k == 8) mh[1] = (mh[1] + 1) % 24;
            sb.push_back(exp_vec());
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL repeat_k%0d obs=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic test_reenable();
        enable = 1'b0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL drop_enable obs=%h exp=%h", obs, e); end
        enable = 1'b1; ch = 5'd7; cm = 6'd5;
        mh[0] = 7; mm[0] = 5; md = '0; mpos = 0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reenable obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_move_and_step();
        bd = 1'b1; br = 1'b1;
        mh[0] = 6; md[0] = 1'b1; mpos = 1;
        sb.push_back(exp_vec());
        tick();
        bd = 1'b0; br = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL move_and_step obs=%h exp=%h", obs, e); end
        bl = 1'b1; mpos = 0;
        sb.push_back(exp_vec());
        tick();
        bl = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL move_back obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_during_repeat();
        bu = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0 || k == 4) mh[0] = (mh[0] + 1) % 24;
            sb.push_back(exp_vec());
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL hold_k%0d obs=%h exp=%h", k, obs, e); end
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        sb.push_back(exp_vec());
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL async_reset obs=%h exp=%h", obs, e); end
        tick();
        tick();
        reset = 1'b0; bu = 1'b0; enable = 1'b0;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL post_reset_idle obs=%h exp=%h", obs, e); end
        enable = 1'b1; ch = 5'd7; cm = 6'd5;
        mh[0] = 7; mm[0] = 5;
        sb.push_back(exp_vec());
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL post_reset_capture obs=%h exp=%h", obs, e); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0;
        ch = '0; cm = '0;
        tick();
        tick();
        test_reset();
        test_capture();
        test_saturate();
        test_carry();
        test_cursor_walk();
        test_simultaneous();
        test_auto_repeat();
        test_reenable();
        test_move_and_step();
        test_reset_during_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
